// File: rtl/codec_adc_capture.sv
// codec_adc_capture: oversampled I2S ADC deserializer for the WM8731 in the CLOCK_50 domain
// clock/reset: system clock, synchronous active-high reset
// bclk/lrclk/adcdat: asynchronous codec serial inputs
// left_sample/right_sample/mono_sample: last complete stereo pair and its mean
// sample_valid: one-cycle strobe on output update; frame_error: one-cycle strobe on short channel
module codec_adc_capture #(
    parameter int WIDTH = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             bclk,
    input  logic             lrclk,
    input  logic             adcdat,
    output logic [WIDTH-1:0] left_sample,
    output logic [WIDTH-1:0] right_sample,
    output logic [WIDTH-1:0] mono_sample,
    output logic             sample_valid,
    output logic             frame_error
);
    localparam int CW = $clog2(WIDTH + 1);
    typedef enum logic [1:0] {IDLE, SKIP, SHIFT, DONE} state_t;
    state_t state, state_n;
    logic [SYNC_STAGES-1:0] bs, ls, ds;
    logic b_d, l_d, ch, ch_n, left_ok, err, commit;
    logic [CW-1:0] cnt, cnt_n;
    logic [WIDTH-1:0] sr, sr_n, hold_l;
    logic [WIDTH:0] sum;
    logic bclk_rise, lr_rise, lr_fall, lr_edge;
    assign bclk_rise = bs[SYNC_STAGES-1] & ~b_d;
    assign lr_rise = ls[SYNC_STAGES-1] & ~l_d;
    assign lr_fall = ~ls[SYNC_STAGES-1] & l_d;
    assign lr_edge = lr_rise | lr_fall;
    assign sum = {hold_l[WIDTH-1], hold_l} + {sr[WIDTH-1], sr};
    // An LRCLK edge wins over a coincident bclk_rise, which then serves as the delay slot
    always_comb begin
        state_n = state;
        ch_n = ch;
        cnt_n = cnt;
        sr_n = sr;
        err = 1'b0;
        commit = 1'b0;
        if ((state == IDLE) ? lr_fall : lr_edge) begin
            err = (state == SKIP) || (state == SHIFT);
            state_n = bclk_rise ? SHIFT : SKIP;
            ch_n = lr_rise;
            cnt_n = '0;
        end else begin
            case (state)
                SKIP: if (bclk_rise) begin
                    state_n = SHIFT;
                    cnt_n = '0;
                end
                SHIFT: if (cnt == CW'(WIDTH)) begin
                    commit = 1'b1;
                    state_n = DONE;
                end else if (bclk_rise) begin
                    sr_n = {sr[WIDTH-2:0], ds[SYNC_STAGES-1]};
                    cnt_n = cnt + CW'(1);
                end
                default: ;
            endcase
        end
    end
    always_ff @(posedge clock) begin
        if (reset) begin
            bs <= '0;
            ls <= '0;
            ds <= '0;
            b_d <= 1'b0;
            l_d <= 1'b0;
            state <= IDLE;
            ch <= 1'b0;
            cnt <= '0;
            sr <= '0;
            hold_l <= '0;
            left_ok <= 1'b0;
            left_sample <= '0;
            right_sample <= '0;
            mono_sample <= '0;
            sample_valid <= 1'b0;
            frame_error <= 1'b0;
        end else begin
            bs <= {bs[SYNC_STAGES-2:0], bclk};
            ls <= {ls[SYNC_STAGES-2:0], lrclk};
            ds <= {ds[SYNC_STAGES-2:0], adcdat};
            b_d <= bs[SYNC_STAGES-1];
            l_d <= ls[SYNC_STAGES-1];
            state <= state_n;
            ch <= ch_n;
            cnt <= cnt_n;
            sr <= sr_n;
            frame_error <= err;
            sample_valid <= commit & ch & left_ok;
            if (err) left_ok <= 1'b0;
            else if (commit) left_ok <= ~ch;
            if (commit && !ch) hold_l <= sr;
            if (commit && ch && left_ok) begin
                left_sample <= hold_l;
                right_sample <= sr;
                mono_sample <= sum[WIDTH:1];
            end
        end
    end
endmodule

// File: doc/codec_adc_capture.md
# codec_adc_capture

Receives the WM8731 ADC serial stream (I2S format, BCLK/ADCLRCK/ADCDAT) by oversampling it in the CLOCK_50 domain. Deserializes both stereo channels and presents them as parallel samples with a one-cycle valid strobe. Sits between the codec pins and `dsp_subsystem`, as a synchronous alternative to the BCLK-clocked deserializer. It detects misaligned or short frames and reports them.

## Interface
- `WIDTH`, 16: bits per channel sample; valid range 8-24.
- `SYNC_STAGES`, 2: synchronizer flops on each async codec input; minimum 2.
- `clock`  in  1  system clock (CLOCK_50); every register is clocked on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `bclk`  in  1  codec AUD_BCLK; asynchronous to `clock`.
- `lrclk`  in  1  codec AUD_ADCLRCK; asynchronous. Low = left, high = right.
- `adcdat`  in  1  codec AUD_ADCDAT; asynchronous.
- `left_sample`  out  WIDTH  last complete left sample, two's complement.
- `right_sample`  out  WIDTH  last complete right sample, two's complement.
- `mono_sample`  out  WIDTH  arithmetic mean of left and right: (L+R)>>>1, computed at WIDTH+1 bits.
- `sample_valid`  out  1  one-cycle pulse when all three sample outputs update together.
- `frame_error`  out  1  one-cycle pulse when an LRCLK edge arrives before WIDTH bits are captured.

## Operation
- **Input sync:** each of bclk, lrclk and adcdat passes through SYNC_STAGES flops. One further flop per line gives the previous value for edge detection.
- **Edge terms:** `bclk_rise` = synced high and previous low. `lr_fall` and `lr_rise` are defined the same way on lrclk.
- **Bit capture:** data is sampled only in a `bclk_rise` cycle, using the synced adcdat of that cycle. Bits arrive MSB first.
- **I2S alignment:** the first `bclk_rise` after an LRCLK edge is a delay slot and is not captured. The next WIDTH rises are captured. Any further rises before the next LRCLK edge are ignored.
- **States:**
  - **IDLE:** entered on reset. Waits for `lr_fall`, then goes to SKIP with channel = left. `lr_rise` is ignored, so capture always begins on a left channel.
  - **SKIP:** on `bclk_rise`, goes to SHIFT with bit counter = 0.
  - **SHIFT:** on `bclk_rise`, shifts in one bit and increments the counter. When the counter reaches WIDTH, it commits the channel and goes to DONE.
  - **DONE:** ignores `bclk_rise`. On an LRCLK edge, goes to SKIP with the channel set by that edge.
- **Commit, left channel:** the shift register is copied to an internal left holding register, and `left_ok` is set.
- **Commit, right channel:**
  - If `left_ok` = 1: `left_sample`, `right_sample` and `mono_sample` update on the same edge, `sample_valid` = 1 for exactly one cycle, and `left_ok` clears.
  - If `left_ok` = 0: the right data is discarded and no valid is issued.
- **Short frame:** an LRCLK edge while in SKIP or SHIFT does the following:
  - pulses `frame_error` for one cycle;
  - discards the partial channel and clears `left_ok`;
  - goes to SKIP for the channel selected by the new edge.
- **Simultaneous events:** if an LRCLK edge and `bclk_rise` occur in the same cycle, the LRCLK edge is processed first, and that `bclk_rise` is consumed as the delay slot. The state goes straight to SHIFT with counter = 0.
- **Reset mid-frame:** the partial frame is lost. Capture restarts at the next `lr_fall` after reset is released.

## Timing
- **Reset values:** all outputs = 0; state = IDLE; shift register, counter, `left_ok` and all synchronizer flops = 0.
- **Latency:** the pin transition of the BCLK rise that carries the right-channel LSB appears as `sample_valid` high SYNC_STAGES+2 `clock` cycles later, i.e. 4 cycles at defaults.
- **Output holding:** sample outputs stay stable between pulses. `sample_valid` is never high on two consecutive cycles.
- **Clock ratio:** `clock` must be at least 4x the BCLK frequency, and each BCLK phase must last at least 2 `clock` periods. Behaviour outside this range is not specified.
- **Handshake:** none. The consumer must accept data on the pulse, because there is no backpressure.

## Test plan
- **Nominal frame:** reset, then send one I2S frame with L=16'h8001 and R=16'h7FFE, with BCLK = `clock`/8. Required: exactly one `sample_valid` pulse, `left_sample`=8001, `right_sample`=7FFE, `mono_sample`=16'hFFFF.
- **Start on right phase:** release reset while lrclk is high, followed by a full right word and then a full frame with L=0005, R=0003. Required: the first right word is ignored and no `frame_error` pulses. One valid pulse follows, with L=0005, R=0003, mono=0004.
- **Short left channel:** toggle lrclk high after 10 left bits. Required: one `frame_error` pulse, no `sample_valid` for that frame. The next good frame (L=1234, R=4321) gives valid with those values.
- **Simultaneous edges:** force lrclk fall and bclk rise into the same synced cycle. Required: that rise is treated as the delay slot, and the captured L equals the transmitted word with no bit shift.
- **Reset mid-SHIFT:** assert reset for 1 cycle in the middle of the right word. Required: all outputs read 0 on the next cycle and no valid is issued for the interrupted frame. Capture resumes at the next lr_fall.
- **Extra bits:** 32-bit I2S slots with WIDTH=16. Required: trailing bits are ignored, and the samples equal the upper 16 bits of each slot.
